ram_bist_ctrl: RTL and testbench
================================

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of RAM words tested, addresses 0..DEPTH-1, legal range 1..256.
REQ-002 Parameter PATTERN, default 8'hA5: base data seed.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle request to run the test.
REQ-006 busy  output  1: high while the test is running.
REQ-007 done  output  1: sticky completion flag.
REQ-008 fail  output  1: sticky; set on any mismatch.
REQ-009 fail_addr  output  8: address of the first mismatch.
REQ-010 fail_data  output  8: data actually read at the first mismatch.
REQ-011 err_cnt  output  8: mismatch count, saturating at 8'hFF.
REQ-012 ram_wr  output  1: RAM write enable; RAM writes on the clk edge where ram_wr=1.
REQ-013 ram_addr  output  8: RAM address.
REQ-014 ram_din  output  8: RAM write data.
REQ-015 ram_dout  input  8: RAM read data, valid the cycle after ram_addr is presented with ram_wr=0.

Function
REQ-016 FSM states: IDLE, WR0, RD0, WR1, RD1, CHK, DONE.
REQ-017 Transitions:
- IDLE or DONE with start=1 -> WR0 next cycle.
- WR0 -> RD0 -> WR1 -> RD1, each after DEPTH cycles.
- RD1 -> CHK; CHK -> DONE after 1 cycle.
- DONE holds until start.
REQ-018 Address counter runs 0..DEPTH-1, one step per cycle in each of WR0/RD0/WR1/RD1, and returns to 0 at each state change.
REQ-019 WR0: ram_wr=1, ram_din=PATTERN^addr. WR1: ram_wr=1, ram_din=~(PATTERN^addr).
REQ-020 RD0/RD1: ram_wr=0; ram_addr=counter; expected value (same formula as the matching write pass) is registered for one cycle.
REQ-021 Compare ram_dout against the registered expected value in the cycle after each read issue. This is pipelined across RD0->WR1 and RD1->CHK, so a read-issue cycle is never stalled.
REQ-022 On mismatch:
- err_cnt increments, saturating at 255.
- fail is set.
- fail_addr and fail_data are captured only when fail was 0 before that compare.
REQ-023 Total run time is 4*DEPTH+2 cycles from the first WR0 cycle to the first DONE cycle.
REQ-024 busy=1 in WR0, RD0, WR1, RD1 and CHK; done=1 only in DONE.
REQ-025 start while busy is ignored.
REQ-026 start in DONE clears done, fail, fail_addr, fail_data and err_cnt, and starts a new run.
REQ-027 Outside the write states: ram_wr=0 and ram_din=0. In IDLE and DONE: ram_addr=0.
REQ-028 If start and a compare occur in the same cycle, the compare result still updates the error flags (start is ignored as per REQ-025).

Reset
REQ-029 rst=0 immediately forces IDLE, independent of clk.
REQ-030 Reset values: all outputs 0, including ram_wr, ram_addr, ram_din, busy, done, fail, fail_addr, fail_data and err_cnt.
REQ-031 Reset mid-run aborts the run with no pending compare; the first start after rst=1 begins a full run.

Structure
REQ-032 Shared package ram_bist_pkg holds:
- the state enum;
- DATA_W=8 and ADDR_W=8;
- a function computing expected data from pass and addr.
REQ-033 Compare/error-capture logic (expected register, err_cnt, fail capture) lives in sub-module ram_bist_chk; the FSM and address counter stay in ram_bist_ctrl.

Verification
REQ-034 Good RAM model, DEPTH=64, PATTERN=A5:
- start -> done after 258 cycles; fail=0, err_cnt=0.
- Writes to addr 0x05 carry A0 (WR0) and 5F (WR1).
REQ-035 Addr 0x10 bit3 stuck-0:
- RD0 passes (B5).
- RD1 reads 42, expecting 4A -> fail=1, fail_addr=10, fail_data=42, err_cnt=1.
REQ-036 Model ignoring addr bit4 (0x1n aliases 0x0n):
- first error at fail_addr=00 with fail_data=B5.
- err_cnt=32 (16 per read pass).
REQ-037 DEPTH=256, ram_dout tied FF -> err_cnt saturates at FF, fail_addr=00, fail_data=FF.
REQ-038 Start handling:
- start pulsed at cycle 10 of a run is ignored; done still arrives at cycle 258.
- start in DONE clears the flags and reruns.
REQ-039 rst=0 at cycle 100 (mid RD0):
- outputs 0 and ram_wr=0 without waiting for a clk edge.
- the next start runs a full 258-cycle clean test.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ============================================================================
// ram_bist_pkg : shared types, widths and data-pattern helper for the RAM BIST
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ram_bist_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6
    } bist_state_e;

    // Pass 0 writes seed^addr, pass 1 writes its complement so every bit toggles.
    function automatic logic [DATA_W-1:0] exp_data(
        input logic [DATA_W-1:0] seed,
        input logic              pass,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] d;
        d = seed ^ addr;
        return pass ? ~d : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bist_chk.sv
// ============================================================================
// ram_bist_chk : read-data compare, error counter and first-failure capture
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ram_bist_chk
    import ram_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_exp,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_cnt
);

    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_exp;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [7:0]        r_err_cnt;
    logic              w_mis;

    // Read data for an issue in cycle N arrives in cycle N+1, so the expected
    // value and address ride one register stage alongside it.
    assign w_mis = r_vld && (ram_dout != r_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld       <= 1'b0;
            r_addr      <= '0;
            r_exp       <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_vld  <= issue;
            r_addr <= issue_addr;
            r_exp  <= issue_exp;
            if (w_mis) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_addr;
                    r_fail_data <= ram_dout;
                end
            end else if (clr) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_err_cnt   <= '0;
            end
        end
    end

    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// ram_bist_ctrl : two-pass write/read march controller for an 8-bit RAM
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                DEPTH   = 64,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_cnt,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_e       r_state;
    bist_state_e       w_state_d;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_d;
    logic              w_last;
    logic              w_issue;
    logic [DATA_W-1:0] w_issue_exp;
    logic              w_clr;

    assign w_last = (r_cnt == C_LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // The counter defaults to 0 so it restarts on every state change.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_d = S_WR0;
                end
            end
            S_WR0: begin
                if (w_last) w_state_d = S_RD0;
                else        w_cnt_d   = r_cnt + 8'd1;
            end
            S_RD0: begin
                if (w_last) w_state_d = S_WR1;
                else        w_cnt_d   = r_cnt + 8'd1;
            end
            S_WR1: begin
                if (w_last) w_state_d = S_RD1;
                else        w_cnt_d   = r_cnt + 8'd1;
            end
            S_RD1: begin
                if (w_last) w_state_d = S_CHK;
                else        w_cnt_d   = r_cnt + 8'd1;
            end
            S_CHK: begin
                w_state_d = S_DONE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        ram_wr      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        w_issue     = 1'b0;
        w_issue_exp = '0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr = start;
            end
            S_WR0: begin
                busy     = 1'b1;
                ram_wr   = 1'b1;
                ram_addr = r_cnt;
                ram_din  = exp_data(PATTERN, 1'b0, r_cnt);
            end
            S_RD0: begin
                busy        = 1'b1;
                ram_addr    = r_cnt;
                w_issue     = 1'b1;
                w_issue_exp = exp_data(PATTERN, 1'b0, r_cnt);
            end
            S_WR1: begin
                busy     = 1'b1;
                ram_wr   = 1'b1;
                ram_addr = r_cnt;
                ram_din  = exp_data(PATTERN, 1'b1, r_cnt);
            end
            S_RD1: begin
                busy        = 1'b1;
                ram_addr    = r_cnt;
                w_issue     = 1'b1;
                w_issue_exp = exp_data(PATTERN, 1'b1, r_cnt);
            end
            S_CHK: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done  = 1'b1;
                w_clr = start;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    ram_bist_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_clr),
        .issue      (w_issue),
        .issue_addr (r_cnt),
        .issue_exp  (w_issue_exp),
        .ram_dout   (ram_dout),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .err_cnt    (err_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// ============================================================================
// tb_ram_bist_ctrl : directed bench with a pass-level model of the BIST run
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_ram_bist_ctrl;

    localparam int          D   = 64;
    localparam logic [7:0]  PAT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail, ram_wr;
    logic [7:0] fail_addr, fail_data, err_cnt, ram_addr, ram_din;
    logic [7:0] ram_dout = 8'h00;

    logic       start2 = 1'b0;
    logic       busy2, done2, fail2, ram_wr2;
    logic [7:0] fail_addr2, fail_data2, err_cnt2, ram_addr2, ram_din2;

    int n_chk  = 0;
    int n_pass = 0;
    int fault_mode = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.DEPTH(D), .PATTERN(PAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
        .err_cnt(err_cnt), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_bist_ctrl #(.DEPTH(256), .PATTERN(PAT)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .fail(fail2), .fail_addr(fail_addr2), .fail_data(fail_data2),
        .err_cnt(err_cnt2), .ram_wr(ram_wr2), .ram_addr(ram_addr2),
        .ram_din(ram_din2), .ram_dout(8'hFF)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- RAM with selectable faults ----------------
    logic [7:0] mem [256];

    function automatic logic [7:0] amap(input logic [7:0] a);
        if (fault_mode == 2 && a[7:4] == 4'h1) return {4'h0, a[3:0]};
        return a;
    endfunction

    function automatic logic [7:0] rfault(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (fault_mode == 1 && a == 8'h10) r[3] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) mem[amap(ram_addr)] <= ram_din;
        ram_dout <= rfault(ram_addr, mem[amap(ram_addr)]);
    end

    // ---------------- run-level model ----------------
    typedef struct packed {
        logic       fail;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } res_t;

    function automatic res_t predict(input int depth);
        logic [7:0] m [256];
        logic [7:0] d, e;
        res_t r;
        int   n;
        r = '0;
        n = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < depth; a++) begin
                e = PAT ^ 8'(a);
                if (p == 1) e = ~e;
                m[amap(8'(a))] = e;
            end
            for (int a = 0; a < depth; a++) begin
                e = PAT ^ 8'(a);
                if (p == 1) e = ~e;
                d = rfault(8'(a), m[amap(8'(a))]);
                if (d != e) begin
                    if (!r.fail) begin
                        r.addr = 8'(a);
                        r.data = d;
                    end
                    r.fail = 1'b1;
                    if (n < 255) n++;
                end
            end
        end
        r.cnt = 8'(n);
        return r;
    endfunction

    // mc: -1 idle, 0..4D-1 pass cycles, 4D check cycle, 4D+1 done
    int   mc   = -1;
    res_t mres = '0;
    res_t mflg = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc   <= -1;
            mflg <= '0;
        end else if (mc < 0 || mc == 4*D+1) begin
            if (start) begin
                mc   <= 0;
                mres <= predict(D);
                mflg <= '0;
            end
        end else begin
            mc <= mc + 1;
            if (mc == 4*D) mflg <= mres;
        end
    end

    always @(negedge clk) begin
        logic       e_busy, e_done, e_wr, chk_addr;
        logic [7:0] e_addr, e_din;
        int         ph, a;
        e_busy   = (mc >= 0) && (mc <= 4*D);
        e_done   = (mc == 4*D+1);
        e_wr     = 1'b0;
        e_addr   = 8'h00;
        e_din    = 8'h00;
        chk_addr = (mc != 4*D);
        if (mc >= 0 && mc < 4*D) begin
            ph     = mc / D;
            a      = mc % D;
            e_addr = 8'(a);
            e_wr   = (ph == 0) || (ph == 2);
            if (ph == 0) e_din = PAT ^ 8'(a);
            if (ph == 2) e_din = ~(PAT ^ 8'(a));
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("ram_wr", ram_wr, e_wr);
        check("ram_din", ram_din, e_din);
        if (chk_addr) check("ram_addr", ram_addr, e_addr);
        if (!e_busy) begin
            check("fail", fail, mflg.fail);
            check("fail_addr", fail_addr, mflg.addr);
            check("fail_data", fail_data, mflg.data);
            check("err_cnt", err_cnt, mflg.cnt);
        end
    end

    logic [7:0] w5_0 = 8'h00;
    logic [7:0] w5_1 = 8'h00;
    always @(negedge clk) begin
        if (rst && ram_wr && ram_addr == 8'h05) begin
            if (mc < D) w5_0 <= ram_din;
            else        w5_1 <= ram_din;
        end
    end

    task automatic run(input bit ign, output int cyc);
        start = 1'b1;
        cyc   = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start = ign && (cyc == 10);
        end while (!done && cyc < 2000);
        start = 1'b0;
        if (!done) check("done_timeout", done, 1'b1);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_err_cnt", err_cnt, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // clean RAM
        fault_mode = 0;
        run(1'b0, cyc);
        check("lat_good", cyc, 258);
        check("good_fail", fail, 1'b0);
        check("good_err", err_cnt, 8'h00);
        check("wr0_addr5", w5_0, 8'hA0);
        check("wr1_addr5", w5_1, 8'h5F);

        // bit3 stuck-0 at 0x10, restarted from DONE
        fault_mode = 1;
        run(1'b0, cyc);
        check("lat_stuck", cyc, 258);
        check("stuck_fail", fail, 1'b1);
        check("stuck_addr", fail_addr, 8'h10);
        check("stuck_data", fail_data, 8'h42);
        check("stuck_err", err_cnt, 8'h01);

        // bit4 aliasing
        fault_mode = 2;
        run(1'b0, cyc);
        check("alias_addr", fail_addr, 8'h00);
        check("alias_data", fail_data, 8'hB5);
        check("alias_err", err_cnt, 8'd32);

        // start while busy ignored; previous flags cleared
        fault_mode = 0;
        run(1'b1, cyc);
        check("lat_ignore", cyc, 258);
        check("ignore_err", err_cnt, 8'h00);

        // async reset mid RD0 with errors accumulating
        fault_mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("pre_rst_err", err_cnt, 8'd16);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_ram_wr", ram_wr, 1'b0);
        check("arst_ram_addr", ram_addr, 8'h00);
        check("arst_fail", fail, 1'b0);
        check("arst_err", err_cnt, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fault_mode = 0;
        run(1'b0, cyc);
        check("lat_after_rst", cyc, 258);
        check("after_rst_fail", fail, 1'b0);

        // DEPTH=256 against a RAM stuck at FF
        start2 = 1'b1;
        cyc    = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start2 = 1'b0;
        end while (!done2 && cyc < 3000);
        check("lat_256", cyc, 1026);
        check("sat_fail", fail2, 1'b1);
        check("sat_err", err_cnt2, 8'hFF);
        check("sat_addr", fail_addr2, 8'h00);
        check("sat_data", fail_data2, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
